// File: rtl/pwm_sequencer.sv
// Table-driven PWM load sequencer: walks a 4-entry {duty, hold} table,
// strobing cs and presenting uptime to a downstream PWM, optionally looping.
module pwm_sequencer #(
  parameter int CS_WIDTH = 1
) (
  input  logic       clkin,
  input  logic       reset,
  input  logic       wr_en,
  input  logic [1:0] wr_addr,
  input  logic [2:0] wr_duty,
  input  logic [7:0] wr_hold,
  input  logic       start,
  input  logic       stop,
  input  logic       loop,
  output logic       cs,
  output logic [2:0] uptime,
  output logic       busy,
  output logic [1:0] step,
  output logic       done
);

  typedef enum logic [1:0] {IDLE, LOAD, HOLD, OFF} state_t;

  localparam logic [7:0] CS_LAST = 8'(CS_WIDTH - 1);

  logic [2:0] duty_tab [4];
  logic [7:0] hold_tab [4];

  state_t     state, state_n;
  logic [7:0] cnt, cnt_n;
  logic [1:0] step_n, step_inc;
  logic       loop_r, loop_n;
  logic [2:0] uptime_n;
  logic       done_n;
  logic [7:0] hold_last;

  always_ff @(posedge clkin) begin
    if (reset) begin
      for (int i = 0; i < 4; i++) begin
        duty_tab[i] <= '0;
        hold_tab[i] <= '0;
      end
    end else if (wr_en) begin
      duty_tab[wr_addr] <= wr_duty;
      hold_tab[wr_addr] <= wr_hold;
    end
  end

  // Counter holds remaining cycles minus one; hold of 0 behaves as 1.
  assign hold_last = (hold_tab[step] == 8'd0) ? 8'd0 : hold_tab[step] - 8'd1;
  assign step_inc  = step + 2'd1;

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    step_n   = step;
    loop_n   = loop_r;
    uptime_n = uptime;
    done_n   = 1'b0;
    case (state)
      IDLE: begin
        if (start && !stop) begin
          state_n  = LOAD;
          step_n   = 2'd0;
          loop_n   = loop;
          cnt_n    = CS_LAST;
          uptime_n = duty_tab[0];
        end
      end
      LOAD: begin
        if (stop) begin
          state_n  = OFF;
          cnt_n    = CS_LAST;
          uptime_n = 3'd0;
        end else if (cnt == 8'd0) begin
          state_n = HOLD;
          cnt_n   = hold_last;
        end else begin
          cnt_n = cnt - 8'd1;
        end
      end
      HOLD: begin
        if (stop) begin
          state_n  = OFF;
          cnt_n    = CS_LAST;
          uptime_n = 3'd0;
        end else if (cnt != 8'd0) begin
          cnt_n = cnt - 8'd1;
        end else if (step != 2'd3) begin
          state_n  = LOAD;
          step_n   = step_inc;
          cnt_n    = CS_LAST;
          uptime_n = duty_tab[step_inc];
        end else if (loop_r) begin
          state_n  = LOAD;
          step_n   = 2'd0;
          cnt_n    = CS_LAST;
          uptime_n = duty_tab[0];
        end else begin
          state_n = IDLE;
          done_n  = 1'b1;
        end
      end
      OFF: begin
        if (cnt == 8'd0) state_n = IDLE;
        else             cnt_n   = cnt - 8'd1;
      end
      default: state_n = IDLE;
    endcase
  end

  // Outputs are registered from the next-state decode so they line up with state.
  always_ff @(posedge clkin) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      step   <= '0;
      loop_r <= 1'b0;
      uptime <= '0;
      cs     <= 1'b0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      step   <= step_n;
      loop_r <= loop_n;
      uptime <= uptime_n;
      cs     <= (state_n == LOAD) || (state_n == OFF);
      busy   <= (state_n != IDLE);
      done   <= done_n;
    end
  end

endmodule

// File: tb/tb_pwm_sequencer.sv
// Directed bench for pwm_sequencer: one CS_WIDTH=1 and one CS_WIDTH=3 instance
// share all inputs; expected traces are hand-computed cycle numbers after start.
module tb_pwm_sequencer;

  logic       clk = 1'b0;
  logic       reset, wr_en, start, stop, loop;
  logic [1:0] wr_addr;
  logic [2:0] wr_duty;
  logic [7:0] wr_hold;

  logic       cs1, busy1, done1, cs3, busy3, done3;
  logic [2:0] uptime1, uptime3;
  logic [1:0] step1, step3;

  int checks = 0;
  int fails  = 0;
  int cy     = 0;

  logic [63:0] cs_tr, done_tr, exp_tr;

  always #5 clk = ~clk;

  pwm_sequencer #(.CS_WIDTH(1)) dut1 (
    .clkin(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_duty(wr_duty), .wr_hold(wr_hold), .start(start), .stop(stop),
    .loop(loop), .cs(cs1), .uptime(uptime1), .busy(busy1), .step(step1),
    .done(done1)
  );

  pwm_sequencer #(.CS_WIDTH(3)) dut3 (
    .clkin(clk), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_duty(wr_duty), .wr_hold(wr_hold), .start(start), .stop(stop),
    .loop(loop), .cs(cs3), .uptime(uptime3), .busy(busy3), .step(step3),
    .done(done3)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cy++;
  endtask

  task automatic wait_to(input int n);
    while (cy < n) tick();
  endtask

  task automatic wr(input logic [1:0] a, input logic [2:0] d, input logic [7:0] h);
    wr_en = 1'b1; wr_addr = a; wr_duty = d; wr_hold = h;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic load_table();
    wr(2'd0, 3'd1, 8'd5);
    wr(2'd1, 3'd2, 8'd3);
    wr(2'd2, 3'd3, 8'd0);
    wr(2'd3, 3'd7, 8'd10);
  endtask

  // Leaves the bench at cycle 1 after the accepting edge.
  task automatic go(input logic lp);
    start = 1'b1; loop = lp;
    tick();
    start = 1'b0;
    cy = 1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset with start and a write pending: reset must win.
    reset = 1'b1; start = 1'b1; stop = 1'b0; loop = 1'b0;
    wr_en = 1'b1; wr_addr = 2'd0; wr_duty = 3'd7; wr_hold = 8'd9;
    tick(); tick();
    reset = 1'b0; start = 1'b0; wr_en = 1'b0;
    chk("rst_outs1", {cs1, uptime1, busy1, step1, done1}, 64'd0);
    chk("rst_outs3", {cs3, uptime3, busy3, step3, done3}, 64'd0);

    // Empty table: four 2-cycle steps, done at cycle 9.
    go(1'b0);
    cs_tr = '0; done_tr = '0;
    for (int c = 1; c <= 10; c++) begin
      cs_tr[c] = cs1; done_tr[c] = done1;
      if (c == 1) chk("empty_up1", uptime1, 3'd0);
      if (c == 8) chk("empty_busy8", busy1, 1'b1);
      if (c == 9) chk("empty_busy9", busy1, 1'b0);
      tick();
    end
    chk("empty_cs", cs_tr, 64'h0AA);
    chk("empty_done", done_tr, 64'h200);
    repeat (10) tick();

    // Table {1/5,2/3,3/0,7/10}, single pass.
    load_table();
    go(1'b0);
    cs_tr = '0; done_tr = '0;
    for (int c = 1; c <= 26; c++) begin
      cs_tr[c] = cs1; done_tr[c] = done1;
      if (c == 1)  chk("seq_up1", uptime1, 3'd1);
      if (c == 7)  chk("seq_up7", uptime1, 3'd2);
      if (c == 11) chk("seq_up11", uptime1, 3'd3);
      if (c == 12) chk("seq_step12", step1, 2'd2);
      if (c == 13) chk("seq_up13", uptime1, 3'd7);
      if (c == 13) chk("seq_step13", step1, 2'd3);
      if (c == 26) chk("seq_upend", uptime1, 3'd7);
      if (c == 26) chk("seq_busyend", busy1, 1'b0);
      tick();
    end
    chk("seq_cs", cs_tr, 64'h2882);
    chk("seq_done", done_tr, 64'h0100_0000);

    // Looping: 23-cycle period, no done.
    go(1'b1);
    cs_tr = '0; done_tr = '0;
    for (int c = 1; c <= 60; c++) begin
      cs_tr[c] = cs1; done_tr[c] = done1;
      if (c == 23) chk("loop_step23", step1, 2'd3);
      if (c == 24) chk("loop_step24", step1, 2'd0);
      if (c == 24) chk("loop_up24", uptime1, 3'd1);
      tick();
    end
    exp_tr = '0;
    foreach (exp_tr[i]) begin
      if (i inside {1, 7, 11, 13, 24, 30, 34, 36, 47, 53, 57, 59}) exp_tr[i] = 1'b1;
    end
    chk("loop_cs", cs_tr, exp_tr);
    chk("loop_done", done_tr, 64'd0);
    stop = 1'b1; tick(); stop = 1'b0;
    chk("loop_off", {cs1, uptime1, busy1}, {1'b1, 3'd0, 1'b1});
    tick();
    chk("loop_idle", {cs1, busy1, done1}, 3'b000);

    // Stop during HOLD of step 2.
    go(1'b0);
    wait_to(12);
    chk("stop_pre", {step1, cs1, busy1}, {2'd2, 1'b0, 1'b1});
    stop = 1'b1; tick(); stop = 1'b0;
    chk("stop_off", {cs1, uptime1, busy1, done1}, {1'b1, 3'd0, 1'b1, 1'b0});
    tick();
    chk("stop_idle", {cs1, busy1, done1}, 3'b000);
    tick();
    chk("stop_nodone", done1, 1'b0);

    // start+stop together in IDLE.
    start = 1'b1; stop = 1'b1; tick(); start = 1'b0; stop = 1'b0;
    chk("startstop", {cs1, busy1}, 2'b00);

    // Start ignored mid-run; write to held entry 1 deferred to next pass.
    go(1'b1);
    wait_to(3);
    start = 1'b1; tick(); start = 1'b0;
    chk("restart_ign", cs1, 1'b0);
    wait_to(7);
    chk("run_step7", {cs1, step1, uptime1}, {1'b1, 2'd1, 3'd2});
    wait_to(8);
    wr(2'd1, 3'd5, 8'd3);
    chk("held_write", uptime1, 3'd2);
    wait_to(24);
    chk("pass2_step0", {cs1, step1, uptime1}, {1'b1, 2'd0, 3'd1});
    wait_to(30);
    chk("pass2_step1", {cs1, step1, uptime1}, {1'b1, 2'd1, 3'd5});
    stop = 1'b1; tick(); stop = 1'b0; tick();
    chk("run_end", busy1, 1'b0);

    // CS_WIDTH=3: reset mid-HOLD, then restart on the cleared table.
    reset = 1'b1; tick(); reset = 1'b0;
    load_table();
    go(1'b0);
    wait_to(5);
    chk("w3_hold", {cs3, busy3, step3, uptime3}, {1'b0, 1'b1, 2'd0, 3'd1});
    reset = 1'b1; tick(); reset = 1'b0;
    chk("w3_rst", {cs3, uptime3, busy3, step3, done3}, 64'd0);
    go(1'b0);
    cs_tr = '0; done_tr = '0;
    for (int c = 1; c <= 18; c++) begin
      cs_tr[c] = cs3; done_tr[c] = done3;
      if (c == 1)  chk("w3_up1", uptime3, 3'd0);
      if (c == 1)  chk("w1_cleared", uptime1, 3'd0);
      if (c == 13) chk("w3_step13", step3, 2'd3);
      if (c == 16) chk("w3_busy16", busy3, 1'b1);
      if (c == 17) chk("w3_busy17", busy3, 1'b0);
      tick();
    end
    chk("w3_cs", cs_tr, 64'hEEEE);
    chk("w3_done", done_tr, 64'h2_0000);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
